// File: rtl/irq_capture_pkg.sv
// Shared types and defaults for the interrupt pending-capture front end.
package irq_capture_pkg;

   typedef enum logic {IDLE, VALID} irq_cap_state_t;

   localparam int NUM_REQ_DEF = 8;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-index-wins priority encoder; bit 0 has the highest priority.
module prio_enc_lsb #(
   parameter  int NUM_REQ = 8,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] in_vec,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Scan from the top down so the lowest set bit is the last to write idx.
   always_comb begin
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (in_vec[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign any = |in_vec;

endmodule

// File: rtl/irq_pending_capture.sv
// Latches request lines into a pending register and hands out the highest-priority index over valid/ready.
// Define IRQ_CAPTURE_EDGE_EN to capture rising edges of req instead of levels.
module irq_pending_capture
   import irq_capture_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_idx,
   output logic [NUM_REQ-1:0] pending,
   output logic [NUM_REQ-1:0] ovf,
   input  logic [NUM_REQ-1:0] ovf_clr
);

   irq_cap_state_t     state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] ovf_q, ovf_d;
   logic [NUM_REQ-1:0] set_vec;
   logic [NUM_REQ-1:0] clr_vec;
   logic [NUM_REQ-1:0] eligible;
   logic [IDX_W-1:0]   sel;
   logic               sel_any;
   logic               handshake;

`ifdef IRQ_CAPTURE_EDGE_EN
   logic [NUM_REQ-1:0] req_q, req_d;

   always_comb begin
      req_d   = req;
      set_vec = req & ~req_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
      end else begin
         req_q <= req_d;
      end
   end
`else
   assign set_vec = req;
`endif

   assign handshake = out_valid_q & out_ready;
   assign eligible  = pending_q & mask;

   prio_enc_lsb #(.NUM_REQ(NUM_REQ)) u_enc (
      .in_vec (eligible),
      .idx    (sel),
      .any    (sel_any)
   );

   // Set beats clear on the same bit, and a fresh overflow beats its own clear strobe.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         clr_vec[i] = handshake && (out_idx_q == IDX_W'(i));
      end
      pending_d = (pending_q & ~clr_vec) | set_vec;
      ovf_d     = (ovf_q & ~ovf_clr) | (set_vec & pending_q & ~clr_vec);
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      unique case (state_q)
         IDLE: begin
            if (sel_any) begin
               out_idx_d   = sel;
               out_valid_d = 1'b1;
               state_d     = VALID;
            end
         end
         VALID: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         pending_q   <= '0;
         ovf_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         pending_q   <= pending_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign pending   = pending_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_irq_pending_capture.sv
// Randomized and directed bench for irq_pending_capture against a cycle-level behavioural model.
// Honours IRQ_CAPTURE_EDGE_EN the same way the design does.
module tb_irq_pending_capture;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         out_valid;
   logic         out_ready;
   logic [2:0]   out_idx;
   logic [N-1:0] pending;
   logic [N-1:0] ovf;
   logic [N-1:0] ovf_clr;

   int checksRun    = 0;
   int checksPassed = 0;
   int grants[$];

   logic [N-1:0] mPend, mOvf, mPrev;
   logic         mValid;
   int           mIdx;

   always #5 clk = ~clk;

   irq_pending_capture #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mask      (mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .pending   (pending),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checksRun++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         checksPassed++;
      end
   endtask

   function automatic int lowestSet(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Advance the reference model by one clock using the rules of the block.
   task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] m, input logic rdy,
                            input logic [N-1:0] oc, input logic rs);
      logic [N-1:0] setV, clrV, nPend, nOvf;
      int           w;
      if (rs) begin
         mPend = '0; mOvf = '0; mValid = 1'b0; mIdx = 0; mPrev = '0;
         return;
      end
`ifdef IRQ_CAPTURE_EDGE_EN
      setV = r & ~mPrev;
`else
      setV = r;
`endif
      clrV  = (mValid && rdy) ? N'(1 << mIdx) : '0;
      nOvf  = (mOvf & ~oc) | (setV & mPend & ~clrV);
      nPend = (mPend & ~clrV) | setV;
      if (mValid) begin
         if (rdy) mValid = 1'b0;
      end else begin
         w = lowestSet(mPend & m);
         if (w >= 0) begin
            mValid = 1'b1;
            mIdx   = w;
         end
      end
      mPend = nPend;
      mOvf  = nOvf;
      mPrev = r;
   endtask

   // Drive one cycle of inputs, step the model, then compare after the edge.
   task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] m, input logic rdy,
                                input logic [N-1:0] oc, input logic rs);
      req = r; mask = m; out_ready = rdy; ovf_clr = oc; rst = rs;
      #1;
      if (!rs && out_valid === 1'b1 && rdy) grants.push_back(int'(out_idx));
      modelStep(r, m, rdy, oc, rs);
      @(posedge clk);
      #1;
      checkOutput("pending", 32'(pending), 32'(mPend));
      checkOutput("ovf", 32'(ovf), 32'(mOvf));
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("out_idx", 32'(out_idx), 32'(mIdx));
   endtask

   task automatic idleCycles(input int n, input logic [N-1:0] m, input logic rdy);
      for (int k = 0; k < n; k++) applyStimulus('0, m, rdy, '0, 1'b0);
   endtask

   initial begin
      int cnt6;
      logic [N-1:0] rr, mm, oc;
      req = '0; mask = '0; out_ready = 1'b0; ovf_clr = '0; rst = 1'b1;
      mPend = '0; mOvf = '0; mValid = 1'b0; mIdx = 0; mPrev = '0;

      // Reset with every request line asserted.
      applyStimulus(8'hFF, 8'hFF, 1'b1, '0, 1'b1);
      applyStimulus(8'hFF, 8'hFF, 1'b1, '0, 1'b1);
      checkOutput("rst_pending", 32'(pending), 32'h0);
      checkOutput("rst_valid", 32'(out_valid), 32'h0);
      idleCycles(2, 8'hFF, 1'b1);

      // Priority order.
      grants.delete();
      applyStimulus(8'b1010_0100, 8'hFF, 1'b1, '0, 1'b0);
      idleCycles(10, 8'hFF, 1'b1);
      checkOutput("prio_count", 32'(grants.size()), 32'd3);
      if (grants.size() == 3) begin
         checkOutput("prio_first", 32'(grants[0]), 32'd2);
         checkOutput("prio_second", 32'(grants[1]), 32'd5);
         checkOutput("prio_third", 32'(grants[2]), 32'd7);
      end
      checkOutput("prio_drained", 32'(pending), 32'h0);

      // Backpressure: index 3 must hold until accepted even when 0 arrives.
      grants.delete();
      applyStimulus(8'h08, 8'hFF, 1'b0, '0, 1'b0);
      idleCycles(5, 8'hFF, 1'b0);
      checkOutput("bp_idx_held", 32'(out_idx), 32'd3);
      applyStimulus(8'h01, 8'hFF, 1'b0, '0, 1'b0);
      checkOutput("bp_idx_still", 32'(out_idx), 32'd3);
      idleCycles(6, 8'hFF, 1'b1);
      checkOutput("bp_count", 32'(grants.size()), 32'd2);
      if (grants.size() == 2) begin
         checkOutput("bp_first", 32'(grants[0]), 32'd3);
         checkOutput("bp_second", 32'(grants[1]), 32'd0);
      end

      // Masked line stays pending without a grant until the mask opens.
      applyStimulus(8'h02, 8'hFD, 1'b1, '0, 1'b0);
      idleCycles(4, 8'hFD, 1'b1);
      checkOutput("mask_pending", 32'(pending), 32'h02);
      checkOutput("mask_no_valid", 32'(out_valid), 32'h0);
      applyStimulus('0, 8'hFF, 1'b0, '0, 1'b0);
      checkOutput("mask_open_idx", 32'(out_idx), 32'd1);
      idleCycles(3, 8'hFF, 1'b1);

      // Set and clear of bit 4 in the same cycle.
      grants.delete();
      applyStimulus(8'h10, 8'hFF, 1'b0, '0, 1'b0);
      applyStimulus('0, 8'hFF, 1'b0, '0, 1'b0);
      applyStimulus(8'h10, 8'hFF, 1'b1, '0, 1'b0);
      checkOutput("coll_pending4", 32'(pending[4]), 32'h1);
      checkOutput("coll_ovf4", 32'(ovf[4]), 32'h0);
      idleCycles(5, 8'hFF, 1'b1);
      checkOutput("coll_count", 32'(grants.size()), 32'd2);

      // Overflow and its write-1-to-clear.
      applyStimulus(8'h40, 8'hBF, 1'b0, '0, 1'b0);
      applyStimulus('0, 8'hBF, 1'b0, '0, 1'b0);
      applyStimulus(8'h40, 8'hBF, 1'b0, '0, 1'b0);
      checkOutput("ovf_set", 32'(ovf), 32'h40);
      applyStimulus('0, 8'hBF, 1'b0, 8'h40, 1'b0);
      checkOutput("ovf_clr", 32'(ovf), 32'h0);
      idleCycles(6, 8'hFF, 1'b1);
      grants.delete();
      for (int k = 0; k < 10; k++) applyStimulus(8'h40, 8'hFF, 1'b1, '0, 1'b0);
      idleCycles(6, 8'hFF, 1'b1);
      cnt6 = 0;
      foreach (grants[g]) if (grants[g] == 6) cnt6++;
`ifdef IRQ_CAPTURE_EDGE_EN
      checkOutput("held_grants", 32'(cnt6), 32'd1);
`else
      checkOutput("held_grants", 32'(cnt6 >= 3), 32'd1);
`endif
      applyStimulus('0, 8'hFF, 1'b1, 8'hFF, 1'b0);

      // Reset while a grant is outstanding.
      applyStimulus(8'h01, 8'hFF, 1'b0, '0, 1'b0);
      applyStimulus('0, 8'hFF, 1'b0, '0, 1'b0);
      applyStimulus('0, 8'hFF, 1'b1, '0, 1'b1);
      checkOutput("rst_mid_valid", 32'(out_valid), 32'h0);
      idleCycles(2, 8'hFF, 1'b1);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         rr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         mm = ($urandom_range(0, 9) < 7) ? 8'hFF : N'($urandom);
         oc = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         applyStimulus(rr, mm, 1'($urandom), oc, ($urandom_range(0, 99) == 0));
      end

      $display("%0d/%0d checks passed", checksPassed, checksRun);
      $finish;
   end

endmodule
